// File: rtl/voice_mixer.sv
// voice_mixer: enveloped multi-voice sample mixer, one shared multiplier, saturating PWM sample per frame
module voice_mixer #(
  parameter int NUM_VOICES    = 5,
  parameter int SAMPLE_W      = 8,
  parameter int OUT_W         = 8,
  parameter int SAMPLE_PERIOD = 4536,
  parameter int ENV_STEP      = 4,
  parameter int MIX_SHIFT     = 2
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             update_in,
  input  logic [NUM_VOICES-1:0]            voice_on_in,
  input  logic [6:0]                       velocity_in [NUM_VOICES],
  input  logic [SAMPLE_W-1:0]              sample_in [NUM_VOICES],
  output logic [OUT_W-1:0]                 pwm_data_out,
  output logic                             pwm_data_ready_out,
  output logic [$clog2(NUM_VOICES+1)-1:0]  active_voices_out,
  output logic [7:0]                       clip_count_out
);
  localparam int CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int AV_W  = $clog2(NUM_VOICES + 1);
  localparam int PRD_W = SAMPLE_W + 9;
  localparam int ACC_W = PRD_W + IDX_W;
  localparam int MIX_W = ACC_W + OUT_W + 1;
  localparam logic [6:0] STEP = 7'(ENV_STEP);
  localparam logic [SAMPLE_W:0] MID = (SAMPLE_W + 1)'(1 << (SAMPLE_W - 1));
  localparam logic signed [MIX_W-1:0] OUT_MID = MIX_W'(1 << (OUT_W - 1));
  localparam logic signed [MIX_W-1:0] OUT_MAX = MIX_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_VOICES-1:0]      on_q, on_d;
  logic [6:0]                 target_q [NUM_VOICES];
  logic [6:0]                 target_d [NUM_VOICES];
  logic [6:0]                 gain_q [NUM_VOICES];
  logic [6:0]                 gain_d [NUM_VOICES];
  logic [SAMPLE_W-1:0]        snap_q [NUM_VOICES];
  logic [SAMPLE_W-1:0]        snap_d [NUM_VOICES];
  logic signed [ACC_W-1:0]    acc_q, acc_d, term;
  logic signed [SAMPLE_W:0]   diff;
  logic signed [PRD_W-1:0]    prod;
  logic signed [MIX_W-1:0]    mix;
  logic [OUT_W-1:0]           pwm_q, pwm_d;
  logic                       ready_q, ready_d;
  logic [7:0]                 clip_q, clip_d;
  logic [AV_W-1:0]            av_q, av_d;
  logic                       tick, start, last, clip;

  function automatic logic [6:0] env_step(input logic [6:0] g, input logic [6:0] t);
    return g < t ? (t - g <= STEP ? t : g + STEP) : (g - t <= STEP ? t : g - STEP);
  endfunction

  assign tick  = cnt_q == CNT_W'(SAMPLE_PERIOD - 1);
  assign start = tick && state_q == IDLE;
  assign last  = idx_q == IDX_W'(NUM_VOICES - 1);

  always_ff @(posedge clk_in)
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = tick ? MAC : IDLE;
      MAC:     state_d = last ? FINISH : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    on_d  = update_in ? voice_on_in : on_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      target_d[i] = update_in ? (voice_on_in[i] ? velocity_in[i] : 7'd0) : target_q[i];
      gain_d[i]   = state_q == FINISH ? env_step(gain_q[i], target_q[i]) : gain_q[i];
      snap_d[i]   = start ? sample_in[i] : snap_q[i];
    end
    // offset-binary sample to signed, scaled by gain/128
    diff  = {1'b0, snap_q[idx_q]} - MID;
    prod  = PRD_W'(diff) * PRD_W'($signed({1'b0, gain_q[idx_q]}));
    term  = ACC_W'(prod) >>> 7;
    acc_d = start ? '0 : state_q == MAC ? acc_q + term : acc_q;
    idx_d = start ? '0 : state_q == MAC ? idx_q + IDX_W'(1) : idx_q;
  end

  always_comb begin
    mix     = MIX_W'(acc_q >>> MIX_SHIFT) + OUT_MID;
    clip    = mix[MIX_W-1] || mix > OUT_MAX;
    pwm_d   = state_q != FINISH ? pwm_q : mix[MIX_W-1] ? '0 : clip ? '1 : mix[OUT_W-1:0];
    ready_d = state_q == FINISH;
    clip_d  = state_q == FINISH && clip && clip_q != 8'hff ? clip_q + 8'd1 : clip_q;
    av_d    = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      av_d = av_d + AV_W'(on_q[i] || gain_q[i] != 7'd0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      on_q     <= '0;
      target_q <= '{default: '0};
      gain_q   <= '{default: '0};
      snap_q   <= '{default: '0};
      acc_q    <= '0;
      pwm_q    <= OUT_W'(1 << (OUT_W - 1));
      ready_q  <= 1'b0;
      clip_q   <= '0;
      av_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      on_q     <= on_d;
      target_q <= target_d;
      gain_q   <= gain_d;
      snap_q   <= snap_d;
      acc_q    <= acc_d;
      pwm_q    <= pwm_d;
      ready_q  <= ready_d;
      clip_q   <= clip_d;
      av_q     <= av_d;
    end
  end

  assign pwm_data_out       = pwm_q;
  assign pwm_data_ready_out = ready_q;
  assign active_voices_out  = av_q;
  assign clip_count_out     = clip_q;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized frame-level check of two mixers (shift 2 and shift 0) against a reference model
module tb_voice_mixer;
  localparam int N = 5;
  localparam int P = 20;
  localparam int ENV = 4;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         update_in = 1'b0;
  logic [N-1:0] voice_on = '0;
  logic [6:0]   vel [N];
  logic [7:0]   smp [N];
  logic [7:0]   pwm_a, pwm_b, clip_a, clip_b;
  logic         rdy_a, rdy_b;
  logic [2:0]   av_a, av_b;
  int cyc, n_chk, n_err, last_wait;
  int m_on [N];
  int m_tgt [N];
  int m_gain [N];
  int m_clip [2];

  voice_mixer #(.NUM_VOICES(N), .SAMPLE_PERIOD(P), .ENV_STEP(ENV), .MIX_SHIFT(2)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .update_in(update_in), .voice_on_in(voice_on),
    .velocity_in(vel), .sample_in(smp), .pwm_data_out(pwm_a), .pwm_data_ready_out(rdy_a),
    .active_voices_out(av_a), .clip_count_out(clip_a));

  voice_mixer #(.NUM_VOICES(N), .SAMPLE_PERIOD(P), .ENV_STEP(ENV), .MIX_SHIFT(0)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .update_in(update_in), .voice_on_in(voice_on),
    .velocity_in(vel), .sample_in(smp), .pwm_data_out(pwm_b), .pwm_data_ready_out(rdy_b),
    .active_voices_out(av_b), .clip_count_out(clip_b));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= rst_in ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_mix(input int shift, output bit clipped);
    int acc = 0;
    int m;
    for (int i = 0; i < N; i++) acc += (m_gain[i] * (int'(smp[i]) - 128)) >>> 7;
    m = (acc >>> shift) + 128;
    clipped = m < 0 || m > 255;
    return m < 0 ? 0 : m > 255 ? 255 : m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_on[i] = 0; m_tgt[i] = 0; m_gain[i] = 0; end
    m_clip[0] = 0;
    m_clip[1] = 0;
  endtask

  task automatic upd();
    update_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_on[i]  = voice_on[i];
      m_tgt[i] = voice_on[i] ? int'(vel[i]) : 0;
    end
    @(negedge clk_in);
    update_in = 1'b0;
  endtask

  task automatic frame();
    int e0, e1, av;
    bit c0, c1;
    last_wait = 0;
    while (!rdy_a && last_wait < 3 * P) begin @(negedge clk_in); last_wait++; end
    if (!rdy_a) begin chk("ready_timeout", 0, 1); return; end
    e0 = model_mix(2, c0);
    e1 = model_mix(0, c1);
    if (c0 && m_clip[0] < 255) m_clip[0]++;
    if (c1 && m_clip[1] < 255) m_clip[1]++;
    chk("ready_phase", cyc % P, N + 1);
    chk("ready_b", rdy_b, 1);
    chk("pwm_shift2", pwm_a, e0);
    chk("pwm_shift0", pwm_b, e1);
    chk("clip_shift2", clip_a, m_clip[0]);
    chk("clip_shift0", clip_b, m_clip[1]);
    for (int i = 0; i < N; i++)
      if (m_gain[i] < m_tgt[i]) m_gain[i] = m_gain[i] + ENV > m_tgt[i] ? m_tgt[i] : m_gain[i] + ENV;
      else m_gain[i] = m_gain[i] - ENV < m_tgt[i] ? m_tgt[i] : m_gain[i] - ENV;
    @(negedge clk_in);
    av = 0;
    for (int i = 0; i < N; i++) av += (m_on[i] != 0 || m_gain[i] != 0) ? 1 : 0;
    chk("ready_width", rdy_a, 0);
    chk("active_voices", av_a, av);
    chk("active_voices_b", av_b, av);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin vel[i] = '0; smp[i] = 8'd128; end
    model_reset();
    repeat (3) @(negedge clk_in);
    chk("reset_pwm", pwm_a, 128);
    chk("reset_ready", rdy_a, 0);
    chk("reset_clip", clip_a, 0);
    chk("reset_active", av_a, 0);
    rst_in = 1'b1;
    frame();
    chk("first_latency", last_wait, P - 1 + 7);

    // attack on voice 0 up to full gain
    voice_on = 5'b00001; vel[0] = 7'd127; smp[0] = 8'd255;
    upd();
    repeat (34) frame();
    chk("attack_settled", pwm_a, 159);
    chk("attack_active", av_a, 1);

    voice_on = '0;
    upd();
    repeat (33) frame();
    chk("release_settled", pwm_a, 128);
    chk("release_active", av_a, 0);

    // update lands on the tick cycle: this frame keeps the old (zero) gains
    while (cyc % P != P - 1) @(negedge clk_in);
    voice_on = 5'b00001; vel[0] = 7'd100;
    upd();
    frame();
    chk("coinc_same_frame", pwm_b, 128);
    frame();
    chk("coinc_next_frame", pwm_b, 131);

    voice_on = 5'b00111;
    for (int i = 0; i < 3; i++) begin vel[i] = 7'd127; smp[i] = 8'd255; end
    upd();
    repeat (34) frame();
    chk("clamp_high", pwm_b, 255);
    for (int i = 0; i < 3; i++) smp[i] = 8'd0;
    repeat (2) frame();
    chk("clamp_low", pwm_b, 0);

    repeat (200) begin
      for (int i = 0; i < N; i++) smp[i] = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        voice_on = N'($urandom);
        for (int i = 0; i < N; i++) vel[i] = 7'($urandom);
        upd();
      end
      frame();
    end

    // reset asserted in the middle of the MAC pass
    while (cyc % P != 2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (N + 4) begin
      @(negedge clk_in);
      chk("midreset_no_ready", rdy_a, 0);
    end
    chk("midreset_pwm", pwm_a, 128);
    chk("midreset_clip", clip_b, 0);
    chk("midreset_active", av_a, 0);
    rst_in = 1'b1;
    model_reset();
    frame();
    chk("midreset_latency", last_wait, P - 1 + 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 5, meaning number of mixed voices (2..16).
REQ-002 SHALL have parameter SAMPLE_W, default 8, meaning width of each unsigned offset-binary voice sample.
REQ-003 SHALL have parameter OUT_W, default 8, meaning PWM output width.
REQ-004 SHALL have parameter SAMPLE_PERIOD, default 4536, meaning clocks per output frame (must exceed NUM_VOICES+3).
REQ-005 SHALL have parameter ENV_STEP, default 4, meaning per-frame gain change of the attack/release envelope (1..127).
REQ-006 SHALL have parameter MIX_SHIFT, default 2, meaning arithmetic right shift applied to the voice sum.
REQ-007 SHALL have one clock and a synchronous, active-low reset: clk_in input 1 (system clock); rst_in input 1 (synchronous reset, active low).
REQ-008 SHALL have update_in input 1, a one-cycle pulse latching voice_on_in and velocity_in.
REQ-009 SHALL have voice_on_in input NUM_VOICES, meaning per-voice note-on flags.
REQ-010 SHALL have velocity_in input [NUM_VOICES][7], meaning per-voice MIDI velocity.
REQ-011 SHALL have sample_in input [NUM_VOICES][SAMPLE_W], meaning live per-voice oscillator samples (midpoint 2^(SAMPLE_W-1) = silence).
REQ-012 SHALL have pwm_data_out output OUT_W, meaning mixed, saturated sample.
REQ-013 SHALL have pwm_data_ready_out output 1, a one-cycle pulse per new pwm_data_out.
REQ-014 SHALL have active_voices_out output clog2(NUM_VOICES+1), meaning the count of sounding voices.
REQ-015 SHALL have clip_count_out output 8, meaning saturating count of clipped frames.

Function
REQ-016 SHALL hold per-voice registers on_q, target_q (7b) and gain_q (7b); target = on_q ? velocity : 0.
REQ-017 SHALL latch on_q/target_q on any update_in cycle, regardless of state; gain_q is unaffected by the latch.
REQ-018 SHALL run a free counter 0..SAMPLE_PERIOD-1 with wrap; tick = counter at SAMPLE_PERIOD-1.
REQ-019 SHALL implement states IDLE, MAC, FINISH: IDLE->MAC on tick; MAC->FINISH after voice NUM_VOICES-1; FINISH->IDLE unconditionally.
REQ-020 SHALL, on the tick edge, snapshot all sample_in, clear the accumulator and set voice index 0.
REQ-021 SHALL, in MAC, process one voice per cycle with a single shared multiplier: term = (gain_q * (sample - 2^(SAMPLE_W-1))) >>> 7, signed, accumulated at full width (no intermediate overflow).
REQ-022 SHALL, in FINISH, compute mix = (acc >>> MIX_SHIFT) + 2^(OUT_W-1), clamp it to [0, 2^OUT_W-1], register it to pwm_data_out, and pulse pwm_data_ready_out.
REQ-023 SHALL make the ready pulse high exactly during cycle T+NUM_VOICES+2, where T is the tick cycle; ready is low otherwise.
REQ-024 SHALL, on a clamp, increment clip_count_out, holding at 255.
REQ-025 SHALL, in FINISH, step each gain_q toward target_q by ENV_STEP without overshoot; the step applies to the next frame only.
REQ-026 SHALL register active_voices_out each cycle as the popcount of (on_q | gain_q != 0).
REQ-027 SHALL make the frame in progress use the old gains when update_in coincides with a tick or MAC.
REQ-028 SHALL ignore a tick outside IDLE (unreachable under REQ-004).

Reset
REQ-029 SHALL, while rst_in=0 at a clock edge, set: pwm_data_out=2^(OUT_W-1); pwm_data_ready_out=0; clip_count_out=0; active_voices_out=0; all on_q/target_q/gain_q=0; counter=0; state=IDLE.
REQ-030 SHALL make reset during MAC or FINISH abort the frame with no ready pulse.

Verification
REQ-031 SHALL verify reset and latency: hold rst_in low for 3 cycles, then release -> pwm_data_out=128 and ready=0; the first ready pulse arrives exactly SAMPLE_PERIOD-1+7 cycles after release (NUM_VOICES=5).
REQ-032 SHALL verify attack: voice0 on, velocity 127, sample 255, update_in -> gain ramps 4,8,...,124,127; once settled, output = ((127*127>>>7)=126>>>2)+128 = 159.
REQ-033 SHALL verify clamping: MIX_SHIFT=0, voices0-2 at velocity 127, samples 255 -> output 255 and clip +1 per frame; with samples 0 -> output 0.
REQ-034 SHALL verify release: after settling, voice0 off -> gain drops 4 per frame to 0; active_voices_out goes 1 -> 0 only when gain reaches 0; output converges to 128.
REQ-035 SHALL verify mid-frame reset: rst_in low during MAC -> no pulse; outputs at reset values.
REQ-036 SHALL verify update/tick coincidence: update_in on the tick cycle -> that frame's output is unchanged; the new gain step is seen in the next frame.
